// File: rtl/keypad_matrix_emulator.sv
// 4x4 keypad responder: returns the col_line bit of the "pressed" key for the scanned row.
// Press commands are queued in a small FIFO and played back with contact bounce, hold and gap timing.
module keypad_matrix_emulator #(
    parameter int FIFO_DEPTH    = 4,
    parameter int BOUNCE_CYCLES = 8,
    parameter int GAP_CYCLES    = 16,
    parameter int HOLD_W        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        row_line,
    output logic [3:0]        col_line,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_key,
    input  logic [HOLD_W-1:0] cmd_hold,
    output logic              contact,
    output logic              busy,
    output logic              done,
    output logic              fifo_full,
    output logic [2:0]        fsm_state
);

    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int BNC_W   = (BOUNCE_CYCLES > 0) ? $clog2(BOUNCE_CYCLES + 1) : 1;
    localparam int GAP_W   = $clog2(GAP_CYCLES + 1);
    localparam int ENTRY_W = 4 + HOLD_W;
    localparam logic [BNC_W-1:0] BNC_LAST = BNC_W'((BOUNCE_CYCLES > 0) ? BOUNCE_CYCLES - 1 : 0);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        BOUNCE_IN  = 3'd1,
        HOLD       = 3'd2,
        BOUNCE_OUT = 3'd3,
        GAP        = 3'd4
    } state_t;

    // Handshake: a command transfers on any clk edge where cmd_valid && cmd_ready;
    // cmd_ready is just !fifo_full and ignores a pop in the same cycle.
    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               push, pop, fifo_empty;
    logic [3:0]         head_key;
    logic [HOLD_W-1:0]  head_hold;

    state_t             state, state_next;
    logic [BNC_W-1:0]   bnc_cnt, bnc_next;
    logic [GAP_W-1:0]   gap_cnt, gap_next;
    logic [HOLD_W-1:0]  hold_cnt, hold_next;
    logic [3:0]         key_q, key_next;
    logic               contact_next, done_next;

    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign cmd_ready  = !fifo_full;
    assign push       = cmd_valid && cmd_ready;
    assign pop        = (state == IDLE) && !fifo_empty;
    assign head_key   = mem[rd_ptr][ENTRY_W-1 -: 4];
    assign head_hold  = mem[rd_ptr][HOLD_W-1:0];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_key, cmd_hold};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            bnc_cnt  <= '0;
            gap_cnt  <= '0;
            hold_cnt <= '0;
            key_q    <= '0;
            contact  <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_next;
            bnc_cnt  <= bnc_next;
            gap_cnt  <= gap_next;
            hold_cnt <= hold_next;
            key_q    <= key_next;
            contact  <= contact_next;
            done     <= done_next;
        end
    end

    // hold_cnt holds the remaining HOLD cycles minus one, so hold=0 behaves as 1.
    always_comb begin
        state_next = state;
        bnc_next   = bnc_cnt;
        gap_next   = gap_cnt;
        hold_next  = hold_cnt;
        key_next   = key_q;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    key_next   = head_key;
                    hold_next  = (head_hold == '0) ? '0 : head_hold - 1'b1;
                    bnc_next   = '0;
                    gap_next   = '0;
                    state_next = (BOUNCE_CYCLES > 0) ? BOUNCE_IN : HOLD;
                end
            end
            BOUNCE_IN: begin
                if (bnc_cnt == BNC_LAST) begin
                    bnc_next   = '0;
                    state_next = HOLD;
                end else begin
                    bnc_next = bnc_cnt + 1'b1;
                end
            end
            HOLD: begin
                if (hold_cnt == '0) begin
                    state_next = (BOUNCE_CYCLES > 0) ? BOUNCE_OUT : GAP;
                end else begin
                    hold_next = hold_cnt - 1'b1;
                end
            end
            BOUNCE_OUT: begin
                if (bnc_cnt == BNC_LAST) begin
                    bnc_next   = '0;
                    state_next = GAP;
                end else begin
                    bnc_next = bnc_cnt + 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    gap_next   = '0;
                    state_next = IDLE;
                end else begin
                    gap_next = gap_cnt + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Contact is registered, so it is derived from where the FSM will be next cycle.
    always_comb begin
        contact_next = 1'b0;
        done_next    = (state == GAP) && (state_next == IDLE);
        case (state_next)
            BOUNCE_IN:  contact_next = ~bnc_next[0];
            HOLD:       contact_next = 1'b1;
            BOUNCE_OUT: contact_next = bnc_next[0];
            default:    contact_next = 1'b0;
        endcase
    end

    always_comb begin
        col_line = 4'b0000;
        if (contact && row_line[key_q[1:0]]) begin
            col_line[key_q[3:2]] = 1'b1;
        end
    end

    assign busy      = (state != IDLE);
    assign fsm_state = state;

endmodule

// File: tb/tb_keypad_matrix_emulator.sv
// Bench for keypad_matrix_emulator: queued press commands are checked cycle by cycle
// against a timing model of bounce, hold and gap, plus reset and FIFO-full corner cases.
module tb_keypad_matrix_emulator;

    localparam int B  = 8;
    localparam int G  = 16;
    localparam int HW = 16;

    logic          clk;
    logic          rst_n;
    logic [3:0]    row_line;
    logic [3:0]    col_line;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [3:0]    cmd_key;
    logic [HW-1:0] cmd_hold;
    logic          contact, busy, done, fifo_full;
    logic [2:0]    fsm_state;

    logic [3:0]    col_line_nb;
    logic          cmd_valid_nb, cmd_ready_nb;
    logic [3:0]    cmd_key_nb;
    logic [HW-1:0] cmd_hold_nb;
    logic          contact_nb, busy_nb, done_nb, fifo_full_nb;
    logic [2:0]    fsm_state_nb;

    int checks   = 0;
    int failures = 0;
    int done_total = 0;

    // {key, expected col nibble, hold}
    logic [23:0] exp_q[$];

    typedef struct {
        logic [3:0]  key;
        logic [3:0]  col;
        logic [15:0] hold;
        int          row_mode;
    } vec_t;
    vec_t vecs[6];

    keypad_matrix_emulator #(
        .FIFO_DEPTH(4), .BOUNCE_CYCLES(B), .GAP_CYCLES(G), .HOLD_W(HW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .row_line(row_line), .col_line(col_line),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_key(cmd_key), .cmd_hold(cmd_hold),
        .contact(contact), .busy(busy), .done(done), .fifo_full(fifo_full), .fsm_state(fsm_state)
    );

    keypad_matrix_emulator #(
        .FIFO_DEPTH(4), .BOUNCE_CYCLES(0), .GAP_CYCLES(G), .HOLD_W(HW)
    ) dut_nb (
        .clk(clk), .rst_n(rst_n), .row_line(row_line), .col_line(col_line_nb),
        .cmd_valid(cmd_valid_nb), .cmd_ready(cmd_ready_nb), .cmd_key(cmd_key_nb),
        .cmd_hold(cmd_hold_nb), .contact(contact_nb), .busy(busy_nb), .done(done_nb),
        .fifo_full(fifo_full_nb), .fsm_state(fsm_state_nb)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_total++;

    initial begin
        #1000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Driver tasks: inputs change 1ns after posedge, outputs are sampled at negedge.
    task automatic next_cycle(input logic [3:0] row);
        @(posedge clk);
        #1 row_line = row;
        @(negedge clk);
    endtask

    function automatic logic [3:0] row_for(input int mode, input int n);
        logic [3:0] one;
        one = 4'b0001;
        case (mode)
            0:       return one << (n % 4);
            1:       return 4'($urandom_range(0, 15));
            2:       return 4'b0000;
            default: return 4'b1111;
        endcase
    endfunction

    task automatic push(input logic [3:0] key, input logic [3:0] col, input logic [15:0] hold,
                        input bit track, input bit expect_accept, input string name);
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_key   = key;
        cmd_hold  = hold;
        @(negedge clk);
        check({name, " cmd_ready"}, cmd_ready, expect_accept);
        if (track && expect_accept) exp_q.push_back({key, col, hold});
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        next_cycle(row_line);
        while (!done && k < 500) begin
            k++;
            next_cycle(row_line);
        end
        if (!done) check({name, " done timeout"}, done, 1);
    endtask

    // Scoreboard consumer: one expected command is popped when a sequence starts,
    // then contact/col_line/done/busy are compared against the timing model.
    task automatic run_seq(input int row_mode, input string name);
        logic [23:0] e;
        logic [3:0]  key, ecol, row;
        logic        exp_c;
        int          h, total, waited;
        waited = 0;
        row = row_for(row_mode, 0);
        next_cycle(row);
        while (!busy && waited <= 200) begin
            waited++;
            row = row_for(row_mode, waited);
            next_cycle(row);
        end
        if (!busy) begin
            check({name, " start timeout"}, busy, 1);
            return;
        end
        if (exp_q.size() == 0) begin
            check({name, " unexpected sequence"}, busy, 0);
            return;
        end
        e     = exp_q.pop_front();
        key   = e[23:20];
        ecol  = e[19:16];
        h     = (e[15:0] == 16'd0) ? 1 : int'(e[15:0]);
        total = 2 * B + h + G;
        for (int n = 0; n <= total; n++) begin
            if (n > 0) begin
                row = row_for(row_mode, n + waited);
                next_cycle(row);
            end
            if (n == total) begin
                check($sformatf("%s done pulse", name), done, 1);
                check($sformatf("%s busy at done", name), busy, 0);
                check($sformatf("%s contact at done", name), contact, 0);
            end else begin
                if (n < B)              exp_c = (n % 2 == 0);
                else if (n < B + h)     exp_c = 1'b1;
                else if (n < 2 * B + h) exp_c = ((n - B - h) % 2 == 1);
                else                    exp_c = 1'b0;
                check($sformatf("%s n=%0d contact", name, n), contact, exp_c);
                check($sformatf("%s n=%0d col_line row=%b", name, n, row), col_line,
                      (exp_c && row[key[1:0]]) ? ecol : 4'b0000);
                check($sformatf("%s n=%0d done", name, n), done, 0);
                check($sformatf("%s n=%0d busy", name, n), busy, 1);
            end
        end
    endtask

    initial begin
        int d0, k, busy_seen, contact_seen;
        rst_n = 1'b0;
        row_line = 4'b0000;
        cmd_valid = 1'b0; cmd_key = '0; cmd_hold = '0;
        cmd_valid_nb = 1'b0; cmd_key_nb = '0; cmd_hold_nb = '0;

        vecs[0] = '{4'h6, 4'b0010, 16'd20, 0};
        vecs[1] = '{4'hD, 4'b1000, 16'd12, 2};
        vecs[2] = '{4'hD, 4'b1000, 16'd12, 3};
        vecs[3] = '{4'h9, 4'b0100, 16'd0,  0};
        vecs[4] = '{4'h3, 4'b0001, 16'd5,  1};
        vecs[5] = '{4'hC, 4'b1000, 16'd1,  1};

        #3;
        check("reset contact", contact, 0);
        check("reset col_line", col_line, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        #19 rst_n = 1'b1;
        @(negedge clk);
        check("post-reset cmd_ready", cmd_ready, 1);
        check("post-reset fifo_full", fifo_full, 0);
        check("post-reset busy", busy, 0);

        // Table of single presses
        #1 d0 = done_total;
        for (int i = 0; i < 6; i++) begin
            push(vecs[i].key, vecs[i].col, vecs[i].hold, 1'b1, 1'b1, $sformatf("vec%0d", i));
            run_seq(vecs[i].row_mode, $sformatf("vec%0d", i));
        end
        #1 check("table done count", done_total - d0, 6);

        // Fill the FIFO behind a running press, then try a fifth push
        push(4'h7, 4'b0000, 16'd30, 1'b0, 1'b1, "fill filler");
        push(4'h0, 4'b0001, 16'd4, 1'b1, 1'b1, "fill k0");
        push(4'h5, 4'b0010, 16'd2, 1'b1, 1'b1, "fill k5");
        push(4'hA, 4'b0100, 16'd3, 1'b1, 1'b1, "fill kA");
        push(4'hF, 4'b1000, 16'd1, 1'b1, 1'b1, "fill kF");
        @(negedge clk);
        check("fill fifo_full", fifo_full, 1);
        check("fill cmd_ready", cmd_ready, 0);
        push(4'h2, 4'b0001, 16'd2, 1'b1, 1'b0, "fill 5th");
        wait_done("fill filler");
        #1 d0 = done_total;
        for (int i = 0; i < 4; i++) run_seq(0, $sformatf("fill seq%0d", i));
        #1 check("fill done count", done_total - d0, 4);
        next_cycle(row_line);
        check("fill no extra busy", busy, 0);

        // No-bounce instance, hold=0
        @(posedge clk);
        #1;
        cmd_valid_nb = 1'b1; cmd_key_nb = 4'h9; cmd_hold_nb = '0; row_line = 4'b0010;
        @(negedge clk);
        check("nb cmd_ready", cmd_ready_nb, 1);
        @(posedge clk);
        #1 cmd_valid_nb = 1'b0;
        @(negedge clk);
        k = 0;
        while (!contact_nb && k < 20) begin
            k++;
            next_cycle(4'b0010);
        end
        check("nb start", contact_nb, 1);
        for (int n = 0; n <= G + 1; n++) begin
            if (n > 0) next_cycle(4'b0010);
            check($sformatf("nb n=%0d contact", n), contact_nb, (n == 0));
            check($sformatf("nb n=%0d col_line", n), col_line_nb, (n == 0) ? 4'b0100 : 4'b0000);
            check($sformatf("nb n=%0d done", n), done_nb, (n == G + 1));
            check($sformatf("nb n=%0d busy", n), busy_nb, (n <= G));
        end

        // Asynchronous reset in the middle of HOLD
        push(4'h6, 4'b0010, 16'd40, 1'b0, 1'b1, "rst first");
        push(4'h1, 4'b0001, 16'd5, 1'b0, 1'b1, "rst queued");
        k = 0;
        while (fsm_state != 3'd2 && k < 100) begin
            k++;
            next_cycle(4'b0100);
        end
        for (int i = 0; i < 5; i++) next_cycle(4'b0100);
        check("pre-reset contact", contact, 1);
        check("pre-reset col_line", col_line, 4'b0010);
        #2 rst_n = 1'b0;
        #1;
        check("async reset contact", contact, 0);
        check("async reset col_line", col_line, 0);
        check("async reset busy", busy, 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        busy_seen = 0;
        contact_seen = 0;
        for (int i = 0; i < 40; i++) begin
            next_cycle(4'b1111);
            if (busy) busy_seen++;
            if (contact) contact_seen++;
        end
        check("after reset busy cycles", busy_seen, 0);
        check("after reset contact cycles", contact_seen, 0);
        check("after reset cmd_ready", cmd_ready, 1);
        check("after reset fifo_full", fifo_full, 0);

        // Full FIFO with a pop in the same cycle as cmd_valid
        push(4'h7, 4'b0000, 16'd30, 1'b0, 1'b1, "pop filler");
        push(4'h1, 4'b0000, 16'd2, 1'b0, 1'b1, "pop f1");
        push(4'h4, 4'b0010, 16'd3, 1'b1, 1'b1, "pop k4");
        push(4'hB, 4'b0100, 16'd4, 1'b1, 1'b1, "pop kB");
        push(4'hE, 4'b1000, 16'd2, 1'b1, 1'b1, "pop kE");
        @(negedge clk);
        check("pop fifo_full", fifo_full, 1);
        wait_done("pop filler");
        cmd_valid = 1'b1; cmd_key = 4'h8; cmd_hold = 16'd6;
        #1 check("pop-cycle cmd_ready", cmd_ready, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("after pop cmd_ready", cmd_ready, 1);
        check("after pop fifo_full", fifo_full, 0);
        exp_q.push_back({4'h8, 4'b0100, 16'd6});
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        check("late push fifo_full", fifo_full, 1);
        wait_done("pop f1");
        for (int i = 0; i < 4; i++) run_seq(0, $sformatf("pop seq%0d", i));
        next_cycle(row_line);
        check("pop no extra busy", busy, 0);
        check("scoreboard drained", exp_q.size(), 0);

        // Final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
